fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the free-running PC-plus-adder loop. It owns the program counter and issues sequential fetch requests to instruction memory over a valid/ready handshake. Returned words are buffered, tagged with their PC, and handed to decode over a second valid/ready handshake. The unit supports stall (enable), branch/jump redirect with discard of in-flight responses, and configurable width, reset vector and buffer depth.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the program counter and issues sequential
//   fetch requests to instruction memory. Returned words are tagged with their
//   PC, buffered in a small FIFO and handed to decode. Supports stall (enable),
//   branch/jump redirect with discard of stale in-flight responses, and
//   wrap-around of the PC modulo 2^ADDR_WIDTH.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   enable                : fetch permitted when high
//   redirect_valid/target : one-cycle redirect, target aligned to the word size
//   req_valid/ready/addr  : fetch request handshake, address = pc
//   rsp_valid/data        : in-order response strobe, always accepted
//   instr_valid/ready     : buffer head handshake towards decode
//   instr_data/pc         : head instruction and its PC
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned            DEPTH        = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  rsp_valid,
   input  logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   localparam int unsigned           STEP       = DATA_WIDTH / 8;
   localparam int unsigned           PTR_W      = $clog2(DEPTH);
   localparam int unsigned           CNT_W      = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STEP - 1);
   localparam logic [CNT_W:0]        CREDITS    = (CNT_W + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]      out_q, out_d;
   logic [CNT_W-1:0]      disc_q, disc_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
   logic [ADDR_WIDTH-1:0] buf_pc_q   [DEPTH];

   logic                  credit_ok;
   logic                  req_fire;
   logic                  rsp_drop;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] target_aligned;

   // In-flight plus buffered words never exceed DEPTH, so a push always
   // finds a free slot.
   assign credit_ok      = ({1'b0, out_q} + {1'b0, count_q}) < CREDITS;
   assign req_valid      = ~reset & enable & ~redirect_valid & credit_ok;
   assign req_addr       = pc_q;
   assign req_fire       = req_valid & req_ready;

   // A response landing in the redirect cycle belongs to the old stream.
   assign rsp_drop       = rsp_valid & (redirect_valid | (disc_q != '0));
   assign push           = rsp_valid & ~rsp_drop;

   assign instr_valid    = (count_q != '0);
   assign pop            = instr_valid & instr_ready;
   assign instr_data     = buf_data_q[rd_ptr_q];
   assign instr_pc       = buf_pc_q[rd_ptr_q];

   assign target_aligned = redirect_target & ~ALIGN_MASK;

   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      out_d    = out_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
      disc_d   = disc_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      if (req_fire) begin
         pc_d = pc_q + STEP_A;
      end
      if (rsp_valid && (disc_q != '0)) begin
         disc_d = disc_q - CNT_W'(1);
      end
      if (push) begin
         rsp_pc_d = rsp_pc_q + STEP_A;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Redirect flushes the buffer and marks every request still in flight
      // (after this cycle's response, if any) as stale.
      if (redirect_valid) begin
         pc_d     = target_aligned;
         rsp_pc_d = target_aligned;
         disc_d   = out_q - CNT_W'(rsp_valid);
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_VECTOR;
         rsp_pc_q <= RESET_VECTOR;
         out_q    <= '0;
         disc_q   <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero until first push.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_data_q[i] <= '0;
            buf_pc_q[i]   <= '0;
         end
      end else if (push) begin
         buf_data_q[wr_ptr_q] <= rsp_data;
         buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // main instance: 32-bit, reset vector 0x100
   logic        reset;
   logic        enable;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   // second instance: 8-bit addresses for wrap-around
   logic        enable8;
   logic        redirect_valid8;
   logic [7:0]  redirect_target8;
   logic        req_valid8;
   logic        req_ready8;
   logic [7:0]  req_addr8;
   logic        rsp_valid8;
   logic [31:0] rsp_data8;
   logic        instr_valid8;
   logic        instr_ready8;
   logic [31:0] instr_data8;
   logic [7:0]  instr_pc8;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int lat       = 1;
   int req_cnt   = 0;

   logic [31:0] rx_pc[$];
   logic [31:0] rx_data[$];
   logic [7:0]  rx8_pc[$];
   logic [31:0] rx8_data[$];

   fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h100), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc)
   );

   fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_VECTOR(8'h00), .DEPTH(4)) dut8 (
      .clock(clock), .reset(reset), .enable(enable8),
      .redirect_valid(redirect_valid8), .redirect_target(redirect_target8),
      .req_valid(req_valid8), .req_ready(req_ready8), .req_addr(req_addr8),
      .rsp_valid(rsp_valid8), .rsp_data(rsp_data8),
      .instr_valid(instr_valid8), .instr_ready(instr_ready8),
      .instr_data(instr_data8), .instr_pc(instr_pc8)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD0000;
   endfunction

   // Memory for the main instance: fixed latency 'lat', in order.
   initial begin
      logic        f;
      logic [31:0] a;
      int          ecount;
      logic [31:0] mq_a[$];
      int          mq_due[$];
      ecount    = 0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      forever begin
         @(negedge clock);
         f = req_valid && req_ready;
         a = req_addr;
         @(posedge clock);
         #1;
         ecount++;
         rsp_valid = 1'b0;
         if (reset) begin
            mq_a.delete();
            mq_due.delete();
            req_cnt = 0;
         end else begin
            if (f) begin
               mq_a.push_back(a);
               mq_due.push_back(ecount + lat - 1);
               req_cnt++;
            end
            if (mq_a.size() > 0 && mq_due[0] <= ecount) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_word(mq_a[0]);
               void'(mq_a.pop_front());
               void'(mq_due.pop_front());
            end
         end
      end
   end

   // Single-cycle memory for the 8-bit instance.
   initial begin
      logic       f8;
      logic [7:0] a8;
      rsp_valid8 = 1'b0;
      rsp_data8  = '0;
      forever begin
         @(negedge clock);
         f8 = req_valid8 && req_ready8;
         a8 = req_addr8;
         @(posedge clock);
         #1;
         rsp_valid8 = f8 && !reset;
         rsp_data8  = 32'h77000000 | {24'h0, a8};
      end
   end

   // Record every instruction handed to decode.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            rx_pc.delete();
            rx_data.delete();
            rx8_pc.delete();
            rx8_data.delete();
         end else begin
            if (instr_valid && instr_ready) begin
               rx_pc.push_back(instr_pc);
               rx_data.push_back(instr_data);
            end
            if (instr_valid8 && instr_ready8) begin
               rx8_pc.push_back(instr_pc8);
               rx8_data.push_back(instr_data8);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
      enable8 = 1'b0; redirect_valid8 = 1'b0; redirect_target8 = '0;
      req_ready8 = 1'b1; instr_ready8 = 1'b1;
      step(3);
      enable = 1'b1;
      #1;
      total_cnt++;
      if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid);
      else pass_cnt++;
      total_cnt++;
      if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
      else pass_cnt++;
      total_cnt++;
      if (instr_data !== 32'h0) $display("FAIL reset_instr_data: got %h want 0", instr_data);
      else pass_cnt++;
      total_cnt++;
      if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc);
      else pass_cnt++;
      total_cnt++;
      if (req_addr !== 32'h100) $display("FAIL reset_req_addr: got %h want 00000100", req_addr);
      else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", req_valid);
      else pass_cnt++;
   endtask

   task automatic test_sequential;
      int          n0;
      logic [31:0] exp_pc;
      step(4);
      n0 = rx_pc.size();
      step(8);
      total_cnt++;
      if (rx_pc.size() - n0 !== 8) $display("FAIL seq_throughput: got %0d want 8", rx_pc.size() - n0);
      else pass_cnt++;
      total_cnt++;
      if (rx_pc.size() !== 10) $display("FAIL seq_count: got %0d want 10", rx_pc.size());
      else pass_cnt++;
      exp_pc = 32'h100;
      for (int i = 0; i < rx_pc.size(); i++) begin
         total_cnt++;
         if (rx_pc[i] !== exp_pc || rx_data[i] !== mem_word(exp_pc))
            $display("FAIL seq_word%0d: got pc=%h data=%h want pc=%h data=%h",
                     i, rx_pc[i], rx_data[i], exp_pc, mem_word(exp_pc));
         else pass_cnt++;
         exp_pc += 32'h4;
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_pc;
      reset = 1'b1; instr_ready = 1'b0; enable = 1'b1; lat = 1;
      step(2);
      reset = 1'b0;
      step(10);
      total_cnt++;
      if (req_cnt !== 4) $display("FAIL bp_req_count: got %0d want 4", req_cnt);
      else pass_cnt++;
      total_cnt++;
      if (req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", req_valid);
      else pass_cnt++;
      total_cnt++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== mem_word(32'h100))
         $display("FAIL bp_head: got v=%b pc=%h data=%h want v=1 pc=00000100 data=%h",
                  instr_valid, instr_pc, instr_data, mem_word(32'h100));
      else pass_cnt++;
      total_cnt++;
      if (rx_pc.size() !== 0) $display("FAIL bp_no_pop: got %0d want 0", rx_pc.size());
      else pass_cnt++;
      instr_ready = 1'b1;
      step(12);
      total_cnt++;
      if (rx_pc.size() < 8) $display("FAIL bp_resume_count: got %0d want >=8", rx_pc.size());
      else pass_cnt++;
      exp_pc = 32'h100;
      for (int i = 0; i < rx_pc.size(); i++) begin
         total_cnt++;
         if (rx_pc[i] !== exp_pc || rx_data[i] !== mem_word(exp_pc))
            $display("FAIL bp_word%0d: got pc=%h data=%h want pc=%h", i, rx_pc[i], rx_data[i], exp_pc);
         else pass_cnt++;
         exp_pc += 32'h4;
      end
   endtask

   task automatic test_redirect;
      logic [31:0] exp_pc;
      reset = 1'b1; lat = 3; instr_ready = 1'b1; enable = 1'b1;
      step(2);
      reset = 1'b0;
      step(2);
      redirect_valid  = 1'b1;
      redirect_target = 32'h2003;
      #1;
      total_cnt++;
      if (req_valid !== 1'b0) $display("FAIL redir_no_req: got %b want 0", req_valid);
      else pass_cnt++;
      step(1);
      redirect_valid = 1'b0;
      #1;
      total_cnt++;
      if (req_valid !== 1'b1 || req_addr !== 32'h2000)
         $display("FAIL redir_first_req: got v=%b addr=%h want v=1 addr=00002000", req_valid, req_addr);
      else pass_cnt++;
      step(15);
      total_cnt++;
      if (rx_pc.size() < 8) $display("FAIL redir_count: got %0d want >=8", rx_pc.size());
      else pass_cnt++;
      exp_pc = 32'h2000;
      for (int i = 0; i < rx_pc.size(); i++) begin
         total_cnt++;
         if (rx_pc[i] !== exp_pc || rx_data[i] !== mem_word(exp_pc))
            $display("FAIL redir_word%0d: got pc=%h data=%h want pc=%h", i, rx_pc[i], rx_data[i], exp_pc);
         else pass_cnt++;
         exp_pc += 32'h4;
      end
   endtask

   task automatic test_enable_toggle;
      int          n;
      int          bad;
      logic [31:0] exp_pc;
      reset = 1'b1; lat = 2; instr_ready = 1'b1; enable = 1'b1;
      step(2);
      reset = 1'b0;
      step(6);
      enable = 1'b0;
      n   = req_cnt;
      bad = 0;
      repeat (5) begin
         #1;
         if (req_valid !== 1'b0) bad++;
         step(1);
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL en_req_valid_low: got %0d cycles high want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (req_cnt !== n) $display("FAIL en_no_new_req: got %0d want %0d", req_cnt, n);
      else pass_cnt++;
      total_cnt++;
      if (rx_pc.size() !== n) $display("FAIL en_inflight_delivered: got %0d want %0d", rx_pc.size(), n);
      else pass_cnt++;
      enable = 1'b1;
      step(10);
      total_cnt++;
      if (rx_pc.size() < n + 5) $display("FAIL en_resume_count: got %0d want >=%0d", rx_pc.size(), n + 5);
      else pass_cnt++;
      exp_pc = 32'h100;
      for (int i = 0; i < rx_pc.size(); i++) begin
         total_cnt++;
         if (rx_pc[i] !== exp_pc || rx_data[i] !== mem_word(exp_pc))
            $display("FAIL en_word%0d: got pc=%h data=%h want pc=%h", i, rx_pc[i], rx_data[i], exp_pc);
         else pass_cnt++;
         exp_pc += 32'h4;
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] exp_pc;
      instr_ready = 1'b0;
      step(8);
      total_cnt++;
      if (instr_valid !== 1'b1) $display("FAIL rmid_full: got %b want 1", instr_valid);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (instr_valid !== 1'b0 || req_valid !== 1'b0)
         $display("FAIL rmid_cleared: got iv=%b rv=%b want 0 0", instr_valid, req_valid);
      else pass_cnt++;
      step(2);
      reset = 1'b0;
      #1;
      total_cnt++;
      if (req_valid !== 1'b1 || req_addr !== 32'h100)
         $display("FAIL rmid_restart: got v=%b addr=%h want v=1 addr=00000100", req_valid, req_addr);
      else pass_cnt++;
      instr_ready = 1'b1;
      step(10);
      total_cnt++;
      if (rx_pc.size() < 6) $display("FAIL rmid_count: got %0d want >=6", rx_pc.size());
      else pass_cnt++;
      exp_pc = 32'h100;
      for (int i = 0; i < rx_pc.size(); i++) begin
         total_cnt++;
         if (rx_pc[i] !== exp_pc || rx_data[i] !== mem_word(exp_pc))
            $display("FAIL rmid_word%0d: got pc=%h data=%h want pc=%h", i, rx_pc[i], rx_data[i], exp_pc);
         else pass_cnt++;
         exp_pc += 32'h4;
      end
   endtask

   task automatic test_wrap;
      redirect_valid8  = 1'b1;
      redirect_target8 = 8'hFE;
      step(1);
      redirect_valid8 = 1'b0;
      enable8         = 1'b1;
      step(6);
      total_cnt++;
      if (rx8_pc.size() < 3) $display("FAIL wrap_count: got %0d want >=3", rx8_pc.size());
      else pass_cnt++;
      if (rx8_pc.size() >= 3) begin
         total_cnt++;
         if (rx8_pc[0] !== 8'hFC || rx8_data[0] !== 32'h770000FC)
            $display("FAIL wrap_first: got pc=%h data=%h want pc=fc data=770000fc", rx8_pc[0], rx8_data[0]);
         else pass_cnt++;
         total_cnt++;
         if (rx8_pc[1] !== 8'h00 || rx8_data[1] !== 32'h77000000)
            $display("FAIL wrap_second: got pc=%h data=%h want pc=00 data=77000000", rx8_pc[1], rx8_data[1]);
         else pass_cnt++;
         total_cnt++;
         if (rx8_pc[2] !== 8'h04) $display("FAIL wrap_third: got pc=%h want 04", rx8_pc[2]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_enable_toggle();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
